// File: rtl/ts_pkg.sv
// ts_pkg: shared constants and types for the MPEG-2 TS stream receiver.
//   TS_PKT_LEN   - transport packet length in bytes
//   TS_SYNC_BYTE - value of the first byte of every packet
//   TS_PID_W     - PID field width
//   TS_CC_W      - continuity-counter field width
//   ts_state_e   - alignment FSM states
package ts_pkg;
  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PID_W     = 13;
  localparam int         TS_CC_W      = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } ts_state_e;
endpackage

// File: rtl/ts_header_parser.sv
// ts_header_parser: extracts TEI/PID from the 4-byte TS header of forwarded
// packets and, when built with TS_CC_CHECK_EN, checks continuity counters.
// Ports:
//   clk, rstn   - clock, asynchronous active-low reset
//   byte_in     - byte being accepted
//   byte_cnt    - position of byte_in within its packet (0..187)
//   accept      - byte_in is forwarded this cycle
//   in_lock     - alignment FSM currently in LOCK
//   pid, tei    - header fields of the current packet (registered)
//   pid_valid   - one-cycle pulse when pid/tei are updated (byte 2)
//   cc_err      - one-cycle pulse on continuity discontinuity (byte 3)
// Macro TS_CC_CHECK_EN: enables continuity tracking; otherwise cc_err is 0.
module ts_header_parser
  import ts_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic [7:0]          byte_in,
  input  logic [7:0]          byte_cnt,
  input  logic                accept,
  input  logic                in_lock,
  output logic [TS_PID_W-1:0] pid,
  output logic                tei,
  output logic                pid_valid,
  output logic                cc_err
);

  logic [TS_PID_W-9:0] pid_hi_q, pid_hi_d;
  logic                tei_pend_q, tei_pend_d;
  logic [TS_PID_W-1:0] pid_q, pid_d;
  logic                tei_q, tei_d;
  logic                pid_valid_q, pid_valid_d;

  // Byte 1 is held until byte 2 so pid and tei change together with pid_valid.
  always_comb begin
    pid_hi_d    = pid_hi_q;
    tei_pend_d  = tei_pend_q;
    pid_d       = pid_q;
    tei_d       = tei_q;
    pid_valid_d = 1'b0;
    if (accept) begin
      case (byte_cnt)
        8'd1: begin
          pid_hi_d   = byte_in[TS_PID_W-9:0];
          tei_pend_d = byte_in[7];
        end
        8'd2: begin
          pid_d       = {pid_hi_q, byte_in};
          tei_d       = tei_pend_q;
          pid_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pid_hi_q    <= '0;
      tei_pend_q  <= 1'b0;
      pid_q       <= '0;
      tei_q       <= 1'b0;
      pid_valid_q <= 1'b0;
    end else begin
      pid_hi_q    <= pid_hi_d;
      tei_pend_q  <= tei_pend_d;
      pid_q       <= pid_d;
      tei_q       <= tei_d;
      pid_valid_q <= pid_valid_d;
    end
  end

  assign pid       = pid_q;
  assign tei       = tei_q;
  assign pid_valid = pid_valid_q;

`ifdef TS_CC_CHECK_EN
  logic [TS_PID_W-1:0] last_pid_q, last_pid_d;
  logic [TS_CC_W-1:0]  last_cc_q, last_cc_d;
  logic [TS_CC_W-1:0]  cc_exp;
  logic                last_vld_q, last_vld_d;
  logic                cc_err_q, cc_err_d;

  // last_vld gates the check so the first packet after (re)lock is never flagged.
  always_comb begin
    last_pid_d = last_pid_q;
    last_cc_d  = last_cc_q;
    last_vld_d = last_vld_q;
    cc_err_d   = 1'b0;
    cc_exp     = last_cc_q + 4'd1;
    if (!in_lock) begin
      last_pid_d = '0;
      last_cc_d  = '0;
      last_vld_d = 1'b0;
    end else if (accept && (byte_cnt == 8'd3)) begin
      if (last_vld_q && (pid_q == last_pid_q) && byte_in[4] &&
          (byte_in[TS_CC_W-1:0] != cc_exp)) begin
        cc_err_d = 1'b1;
      end
      last_pid_d = pid_q;
      last_cc_d  = byte_in[TS_CC_W-1:0];
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_pid_q <= '0;
      last_cc_q  <= '0;
      last_vld_q <= 1'b0;
      cc_err_q   <= 1'b0;
    end else begin
      last_pid_q <= last_pid_d;
      last_cc_q  <= last_cc_d;
      last_vld_q <= last_vld_d;
      cc_err_q   <= cc_err_d;
    end
  end

  assign cc_err = cc_err_q;
`else
  logic unused_in_lock;
  assign unused_in_lock = in_lock;
  assign cc_err         = 1'b0;
`endif

endmodule

// File: rtl/ts_stream_receiver.sv
// ts_stream_receiver: reader end of the output FIFO. Acquires MPEG-2 TS
// packet alignment, forwards aligned bytes with start/end markers, parses
// the header and keeps sync-error / packet statistics.
// Ports:
//   rclk, rstn    - clock, asynchronous active-low reset
//   in_word       - {valid, sync, data[7:0]}; valid at bit DATA_WIDTH
//   locked        - FSM in LOCK
//   byte_out, byte_valid, pkt_start, pkt_end - forwarded byte stream
//   pid, pid_valid, tei, cc_err - header fields / continuity error
//   sync_err_cnt  - saturating boundary/stray-sync error count
//   pkt_cnt       - wrapping count of packets completed in LOCK
// Macro TS_CC_CHECK_EN (in ts_header_parser) enables continuity checking.
// All outputs are registered: one rclk after the accepted input byte.
module ts_stream_receiver
  import ts_pkg::*;
#(
  parameter int DATA_WIDTH    = 9,
  parameter int LOCK_THRESH   = 3,
  parameter int UNLOCK_THRESH = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 rclk,
  input  logic                 rstn,
  input  logic [DATA_WIDTH:0]  in_word,
  output logic                 locked,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  output logic                 pkt_start,
  output logic                 pkt_end,
  output logic [TS_PID_W-1:0]  pid,
  output logic                 pid_valid,
  output logic                 tei,
  output logic                 cc_err,
  output logic [CNT_WIDTH-1:0] sync_err_cnt,
  output logic [CNT_WIDTH-1:0] pkt_cnt
);

  localparam logic [7:0] LAST_IDX = 8'(TS_PKT_LEN - 1);
  localparam logic [7:0] LOCK_T   = 8'(LOCK_THRESH);
  localparam logic [7:0] UNLOCK_T = 8'(UNLOCK_THRESH);

  ts_state_e            state_q, state_d;
  logic [7:0]           byte_cnt_q, byte_cnt_d;
  logic [7:0]           good_q, good_d;
  logic [7:0]           miss_q, miss_d;
  logic [CNT_WIDTH-1:0] sync_err_cnt_q, sync_err_cnt_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]           byte_out_q, byte_out_d;
  logic                 byte_valid_q, byte_valid_d;
  logic                 pkt_start_q, pkt_start_d;
  logic                 pkt_end_q, pkt_end_d;

  logic       vld, sy, boundary, good_byte, serr_inc, fwd;
  logic [7:0] dat, cnt_next;

  always_comb begin
    vld       = in_word[DATA_WIDTH];
    sy        = in_word[8];
    dat       = in_word[7:0];
    boundary  = (byte_cnt_q == 8'd0);
    good_byte = sy && (dat == TS_SYNC_BYTE);
    cnt_next  = (byte_cnt_q == LAST_IDX) ? 8'd0 : byte_cnt_q + 8'd1;

    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    good_d     = good_q;
    miss_d     = miss_q;
    serr_inc   = 1'b0;
    fwd        = 1'b0;

    if (vld) begin
      case (state_q)
        HUNT: begin
          if (good_byte) begin
            state_d    = VERIFY;
            byte_cnt_d = 8'd1;
            good_d     = 8'd1;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (good_byte) begin
              good_d     = good_q + 8'd1;
              byte_cnt_d = cnt_next;
              // The boundary that completes lock is forwarded as byte 0.
              if (good_q + 8'd1 == LOCK_T) begin
                state_d = LOCK;
                miss_d  = 8'd0;
                fwd     = 1'b1;
              end
            end else begin
              state_d    = HUNT;
              byte_cnt_d = 8'd0;
              good_d     = 8'd0;
              serr_inc   = 1'b1;
            end
          end else if (sy) begin
            state_d    = HUNT;
            byte_cnt_d = 8'd0;
            good_d     = 8'd0;
            serr_inc   = 1'b1;
          end else begin
            byte_cnt_d = cnt_next;
          end
        end
        LOCK: begin
          byte_cnt_d = cnt_next;
          fwd        = 1'b1;
          if (boundary) begin
            if (good_byte) begin
              miss_d = 8'd0;
            end else begin
              serr_inc = 1'b1;
              miss_d   = miss_q + 8'd1;
              // Losing lock on this byte suppresses its forwarding.
              if (miss_q + 8'd1 == UNLOCK_T) begin
                state_d    = HUNT;
                byte_cnt_d = 8'd0;
                miss_d     = 8'd0;
                good_d     = 8'd0;
                fwd        = 1'b0;
              end
            end
          end else if (sy) begin
            serr_inc = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    byte_valid_d   = fwd;
    pkt_start_d    = fwd && boundary;
    pkt_end_d      = fwd && (byte_cnt_q == LAST_IDX);
    byte_out_d     = fwd ? dat : byte_out_q;
    pkt_cnt_d      = (fwd && (byte_cnt_q == LAST_IDX)) ? pkt_cnt_q + CNT_WIDTH'(1) : pkt_cnt_q;
    sync_err_cnt_d = (serr_inc && (sync_err_cnt_q != '1)) ? sync_err_cnt_q + CNT_WIDTH'(1)
                                                          : sync_err_cnt_q;
  end

  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= HUNT;
      byte_cnt_q     <= '0;
      good_q         <= '0;
      miss_q         <= '0;
      sync_err_cnt_q <= '0;
      pkt_cnt_q      <= '0;
      byte_out_q     <= '0;
      byte_valid_q   <= 1'b0;
      pkt_start_q    <= 1'b0;
      pkt_end_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      good_q         <= good_d;
      miss_q         <= miss_d;
      sync_err_cnt_q <= sync_err_cnt_d;
      pkt_cnt_q      <= pkt_cnt_d;
      byte_out_q     <= byte_out_d;
      byte_valid_q   <= byte_valid_d;
      pkt_start_q    <= pkt_start_d;
      pkt_end_q      <= pkt_end_d;
    end
  end

  ts_header_parser u_hdr (
    .clk       (rclk),
    .rstn      (rstn),
    .byte_in   (dat),
    .byte_cnt  (byte_cnt_q),
    .accept    (fwd),
    .in_lock   (state_q == LOCK),
    .pid       (pid),
    .tei       (tei),
    .pid_valid (pid_valid),
    .cc_err    (cc_err)
  );

  assign locked       = (state_q == LOCK);
  assign byte_out     = byte_out_q;
  assign byte_valid   = byte_valid_q;
  assign pkt_start    = pkt_start_q;
  assign pkt_end      = pkt_end_q;
  assign sync_err_cnt = sync_err_cnt_q;
  assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_ts_stream_receiver.sv
// Scoreboard bench for ts_stream_receiver: the driver pushes the expected
// forwarded byte (with markers and header fields) for every byte it sends
// while lock is expected; a monitor pops and compares on each byte_valid.
module tb_ts_stream_receiver;
  localparam int DW = 9;
  localparam int CW = 16;
`ifdef TS_CC_CHECK_EN
  localparam bit CC_ON = 1'b1;
`else
  localparam bit CC_ON = 1'b0;
`endif

  logic          rclk = 1'b0;
  logic          rstn = 1'b1;
  logic [DW:0]   in_word;
  logic          locked, byte_valid, pkt_start, pkt_end, pid_valid, tei, cc_err;
  logic [7:0]    byte_out;
  logic [12:0]   pid;
  logic [CW-1:0] sync_err_cnt, pkt_cnt;

  ts_stream_receiver dut (
    .rclk(rclk), .rstn(rstn), .in_word(in_word), .locked(locked),
    .byte_out(byte_out), .byte_valid(byte_valid), .pkt_start(pkt_start),
    .pkt_end(pkt_end), .pid(pid), .pid_valid(pid_valid), .tei(tei),
    .cc_err(cc_err), .sync_err_cnt(sync_err_cnt), .pkt_cnt(pkt_cnt)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [7:0]  data;
    logic        st;
    logic        en;
    logic        pv;
    logic [12:0] pid;
    logic        tei;
    logic        cce;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   gaps    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: compare every forwarded byte against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge rclk);
      if (rstn) begin
        if (byte_valid) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte: actual byte_out=%0h required no byte", byte_out);
          end else begin
            e = sb_q.pop_front();
            chk("byte_out", byte_out, e.data);
            chk("pkt_start", pkt_start, e.st);
            chk("pkt_end", pkt_end, e.en);
            chk("pid_valid", pid_valid, e.pv);
            chk("cc_err", cc_err, e.cce);
            if (e.pv) begin
              chk("pid", pid, e.pid);
              chk("tei", tei, e.tei);
            end
          end
        end else begin
          chk("idle_pulses", {cc_err, pid_valid, pkt_start, pkt_end}, 4'b0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_byte(input logic sy, input logic [7:0] d);
    if (gaps) begin
      while ($urandom_range(0, 99) < 30) begin
        @(posedge rclk); #1 in_word = '0;
      end
    end
    @(posedge rclk); #1 in_word = {1'b1, sy, d};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge rclk); #1 in_word = '0;
    end
  endtask

  // One packet: header {0x47, tei/pid_hi, pid_lo, 0x10|cc}, then filler.
  task automatic send_pkt(input logic [12:0] p, input logic t, input logic [3:0] cc,
                          input bit fwd, input bit cce, input int stray,
                          input bit bad, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      logic [7:0] d;
      logic       sy;
      exp_t       e;
      case (i)
        0:       d = bad ? 8'h00 : 8'h47;
        1:       d = {t, 2'b00, p[12:8]};
        2:       d = p[7:0];
        3:       d = {4'h1, cc};
        default: d = (i == stray) ? 8'h47 : 8'(i * 13 + int'(cc));
      endcase
      sy = (i == 0) || (i == stray);
      if (fwd) begin
        e.data = d;
        e.st   = (i == 0);
        e.en   = (i == 187);
        e.pv   = (i == 2);
        e.pid  = (i == 2) ? p : 13'h0;
        e.tei  = (i == 2) ? t : 1'b0;
        e.cce  = (i == 3) && cce && CC_ON;
        sb_q.push_back(e);
      end
      drive_byte(sy, d);
    end
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    in_word = '0;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_out", byte_out, 0);
    chk("rst_pkt_start", pkt_start, 0);
    chk("rst_pkt_end", pkt_end, 0);
    chk("rst_pid", pid, 0);
    chk("rst_pid_valid", pid_valid, 0);
    chk("rst_tei", tei, 0);
    chk("rst_cc_err", cc_err, 0);
    chk("rst_sync_err_cnt", sync_err_cnt, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    repeat (2) @(posedge rclk);
    sb_q.delete();
    @(negedge rclk);
    rstn = 1'b1;
  endtask

  task automatic end_chk(input string nm, input int epk, input int eser, input bit elk);
    idle(4);
    chk({nm, "_sb_empty"}, sb_q.size(), 0);
    chk({nm, "_pkt_cnt"}, pkt_cnt, epk);
    chk({nm, "_sync_err_cnt"}, sync_err_cnt, eser);
    chk({nm, "_locked"}, locked, elk);
  endtask

  initial begin
    logic [3:0] ccs [5];
    ccs = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
    in_word = '0;
    do_reset();

    // Clean stream: lock on the 3rd boundary, packets 2..4 forwarded.
    for (int p = 0; p < 5; p++) send_pkt(13'h100, 1'b0, 4'(p), p >= 2, 1'b0, -1, 1'b0, 188);
    end_chk("clean", 3, 0, 1'b1);

    // Same stream with valid bubbles.
    do_reset();
    gaps = 1'b1;
    for (int p = 0; p < 5; p++) send_pkt(13'h100, 1'b0, 4'(p), p >= 2, 1'b0, -1, 1'b0, 188);
    end_chk("gaps", 3, 0, 1'b1);
    gaps = 1'b0;

    // Loss of sync: two bad boundaries, then reacquire.
    do_reset();
    for (int p = 0; p < 4; p++) send_pkt(13'h100, 1'b0, 4'(p), p >= 2, 1'b0, -1, 1'b0, 188);
    send_pkt(13'h100, 1'b0, 4'd4, 1'b1, 1'b0, -1, 1'b1, 188);
    idle(3);
    chk("loss_serr1", sync_err_cnt, 1);
    chk("loss_locked_after_1", locked, 1);
    send_pkt(13'h100, 1'b0, 4'd5, 1'b0, 1'b0, -1, 1'b1, 188);
    idle(3);
    chk("loss_serr2", sync_err_cnt, 2);
    chk("loss_locked_after_2", locked, 0);
    for (int p = 6; p < 9; p++) send_pkt(13'h100, 1'b0, 4'(p), p == 8, 1'b0, -1, 1'b0, 188);
    end_chk("loss", 4, 2, 1'b1);

    // Stray sync at byte 50 while locked.
    do_reset();
    for (int p = 0; p < 5; p++)
      send_pkt(13'h100, 1'b0, 4'(p), p >= 2, 1'b0, (p == 3) ? 50 : -1, 1'b0, 188);
    end_chk("stray", 3, 1, 1'b1);

    // Header fields and continuity: CC 3,4,6 on locked packets.
    do_reset();
    for (int p = 0; p < 5; p++) send_pkt(13'h1FFF, 1'b1, ccs[p], p >= 2, p == 4, -1, 1'b0, 188);
    end_chk("hdr", 3, 0, 1'b1);
    chk("hdr_pid", pid, 13'h1FFF);
    chk("hdr_tei", tei, 1);

    // Reset at byte 90 of a locked packet, then clean reacquisition.
    do_reset();
    for (int p = 0; p < 3; p++) send_pkt(13'h0AB, 1'b0, 4'(p), p >= 2, 1'b0, -1, 1'b0, 188);
    send_pkt(13'h0AB, 1'b0, 4'd3, 1'b1, 1'b0, -1, 1'b0, 90);
    idle(3);
    chk("mid_sb_empty", sb_q.size(), 0);
    chk("mid_locked", locked, 1);
    do_reset();
    idle(2);
    chk("post_rst_locked", locked, 0);
    chk("post_rst_pkt_cnt", pkt_cnt, 0);
    for (int p = 0; p < 3; p++) send_pkt(13'h0AB, 1'b0, 4'(p), p >= 2, 1'b0, -1, 1'b0, 188);
    end_chk("reacq", 1, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
